// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first unsigned magnitude comparator with one-hot equal/lesser/greater result.
// Latency: 1 cycle when en=0, else k+1 cycles (k = first differing bit from MSB, WIDTH if equal).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module serial_mag_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             equal,
    output logic             lesser,
    output logic             greater,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [CW-1:0]    cnt;
    logic             sa_msb;
    logic             sb_msb;
    logic             bits_differ;
    logic             last_bit;

    assign sa_msb      = sa[WIDTH-1];
    assign sb_msb      = sb[WIDTH-1];
    assign bits_differ = sa_msb ^ sb_msb;
    assign last_bit    = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = en ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (bits_differ || last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Flags are only ever set on the SHIFT->DONE transition, so they are zero outside DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa      <= '0;
            sb      <= '0;
            cnt     <= '0;
            equal   <= 1'b0;
            lesser  <= 1'b0;
            greater <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sa      <= a;
                        sb      <= b;
                        cnt     <= CW'(WIDTH - 1);
                        equal   <= 1'b0;
                        lesser  <= 1'b0;
                        greater <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bits_differ) begin
                        greater <= sa_msb;
                        lesser  <= sb_msb;
                    end else if (last_bit) begin
                        equal <= 1'b1;
                    end else begin
                        sa  <= sa << 1;
                        sb  <= sb << 1;
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        equal   <= 1'b0;
                        lesser  <= 1'b0;
                        greater <= 1'b0;
                    end
                end
                default: begin
                    equal   <= 1'b0;
                    lesser  <= 1'b0;
                    greater <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator: WIDTH=4 (directed table + exhaustive) and WIDTH=7 (random),
// each instance watched by a queue-based scoreboard.
module tb_serial_mag_comparator;

    localparam int NI = 2;

    typedef struct {
        logic [6:0] a;
        logic [6:0] b;
        logic       en;
        longint     acc_edge;
    } txn_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       en;
        logic [2:0] flags;
        int         lat;
        bit         hold;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NI-1:0][6:0] a_p;
    logic [NI-1:0][6:0] b_p;
    logic [NI-1:0]      in_valid_v;
    logic [NI-1:0]      en_v;
    logic [NI-1:0]      out_ready_v;
    logic [NI-1:0]      in_ready_v;
    logic [NI-1:0]      out_valid_v;
    logic [NI-1:0]      eq_v;
    logic [NI-1:0]      lt_v;
    logic [NI-1:0]      gt_v;
    logic [NI-1:0]      busy_v;
    bit   [NI-1:0]      held_v;

    int     n_cmp = 0;
    int     n_err = 0;
    longint cyc = 0;
    int     acc_cnt [NI];
    int     res_cnt [NI];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference latency: 1 if disabled, else 1 + position of first differing bit from MSB.
    function automatic int exp_lat(input int w, input logic [6:0] a, input logic [6:0] b, input logic en);
        if (!en) return 1;
        for (int i = w - 1; i >= 0; i--) begin
            if (a[i] != b[i]) return (w - i) + 1;
        end
        return w + 1;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int W = (g == 0) ? 4 : 7;

        serial_mag_comparator #(.WIDTH(W)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a_p[g][W-1:0]),
            .b         (b_p[g][W-1:0]),
            .en        (en_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .equal     (eq_v[g]),
            .lesser    (lt_v[g]),
            .greater   (gt_v[g]),
            .busy      (busy_v[g])
        );

        txn_t       q[$];
        logic       pv_ov;
        logic       pv_ordy;
        logic [2:0] pv_flags;
        longint     first_ov;
        longint     last_acc;
        int         done_cyc;
        int         prev_span;
        bit         prev_ok;

        always @(negedge clk) begin
            logic [2:0] fl;
            logic [2:0] ef;
            txn_t       t;
            int         lat;
            fl = {eq_v[g], lt_v[g], gt_v[g]};
            if (!rst_n) begin
                acc_cnt[g] -= q.size();
                q.delete();
                pv_ov   = 1'b0;
                pv_ordy = 1'b0;
                prev_ok = 1'b0;
            end else begin
                check($sformatf("busy_vs_ready_%0d", g), busy_v[g], !in_ready_v[g]);
                if (!out_valid_v[g]) begin
                    check($sformatf("flags_low_idle_%0d", g), fl, 3'b000);
                end else begin
                    if (!pv_ov) begin
                        first_ov = cyc;
                        done_cyc = 0;
                    end else if (!pv_ordy) begin
                        check($sformatf("flags_held_%0d", g), fl, pv_flags);
                    end
                    done_cyc++;
                    if (out_ready_v[g]) begin
                        if (q.size() == 0) begin
                            check($sformatf("orphan_result_%0d", g), 1, 0);
                        end else begin
                            t = q.pop_front();
                            res_cnt[g]++;
                            ef  = t.en ? {t.a == t.b, t.a < t.b, t.a > t.b} : 3'b000;
                            lat = exp_lat(W, t.a, t.b, t.en);
                            check($sformatf("flags_%0d a=%0d b=%0d en=%0d", g, t.a, t.b, t.en), fl, ef);
                            check($sformatf("latency_%0d a=%0d b=%0d", g, t.a, t.b),
                                  first_ov - t.acc_edge + 1, lat);
                            prev_span = lat + done_cyc;
                            prev_ok   = held_v[g];
                        end
                    end
                end
                if (in_valid_v[g] && in_ready_v[g]) begin
                    if (held_v[g] && prev_ok) begin
                        check($sformatf("accept_spacing_%0d", g), cyc + 1 - last_acc, prev_span);
                    end
                    last_acc = cyc + 1;
                    prev_ok  = 1'b0;
                    t.a        = 7'(a_p[g][W-1:0]);
                    t.b        = 7'(b_p[g][W-1:0]);
                    t.en       = en_v[g];
                    t.acc_edge = cyc + 1;
                    q.push_back(t);
                    acc_cnt[g]++;
                end
                pv_ov    = out_valid_v[g];
                pv_ordy  = out_ready_v[g];
                pv_flags = fl;
            end
        end
    end

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit acc;
        out_ready_v[0] = !v.hold;
        a_p[0]         = 7'(v.a);
        b_p[0]         = 7'(v.b);
        en_v[0]        = v.en;
        in_valid_v[0]  = 1'b1;
        lat = 0;
        do begin
            acc = in_ready_v[0];
            @(posedge clk); #1;
            lat++;
        end while (!acc && lat < 20);
        in_valid_v[0] = 1'b0;
        a_p[0]        = ~a_p[0];
        b_p[0]        = 7'h55;
        en_v[0]       = ~v.en;
        check($sformatf("vec%0d_accepted", idx), acc, 1'b1);
        lat = 1;
        while (!out_valid_v[0] && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("vec%0d_latency", idx), lat, v.lat);
        check($sformatf("vec%0d_flags", idx), {eq_v[0], lt_v[0], gt_v[0]}, v.flags);
        if (v.hold) begin
            repeat (3) begin
                @(posedge clk); #1;
                check($sformatf("vec%0d_hold_valid", idx), out_valid_v[0], 1'b1);
                check($sformatf("vec%0d_hold_flags", idx), {eq_v[0], lt_v[0], gt_v[0]}, v.flags);
            end
            out_ready_v[0] = 1'b1;
        end
        @(posedge clk); #1;
        check($sformatf("vec%0d_released", idx), {out_valid_v[0], in_ready_v[0]}, 2'b01);
    endtask

    task automatic rand_run(input int d, input int w, input int n, input bit exh);
        int i;
        int guard;
        bit acc;
        logic [6:0] mask;
        mask = 7'((1 << w) - 1);
        i = 0;
        guard = 0;
        held_v[d] = 1'b1;
        a_p[d]  = exh ? 7'(i[7:4]) : 7'($urandom) & mask;
        b_p[d]  = exh ? 7'(i[3:0]) : 7'($urandom) & mask;
        en_v[d] = ($urandom_range(0, 7) != 0);
        in_valid_v[d] = 1'b1;
        while (i < n && guard < 20000) begin
            acc = in_ready_v[d];
            @(posedge clk); #1;
            guard++;
            out_ready_v[d] = ($urandom_range(0, 2) != 0);
            if (acc) begin
                i++;
                a_p[d]  = exh ? 7'(i[7:4]) : 7'($urandom) & mask;
                b_p[d]  = exh ? 7'(i[3:0]) : 7'($urandom) & mask;
                en_v[d] = ($urandom_range(0, 7) != 0);
            end
        end
        in_valid_v[d] = 1'b0;
        check($sformatf("rand_%0d_all_accepted", d), i, n);
        out_ready_v[d] = 1'b1;
        guard = 0;
        while (busy_v[d] && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check($sformatf("rand_%0d_drained", d), busy_v[d], 1'b0);
        held_v[d] = 1'b0;
    endtask

    vec_t vecs[10];

    initial begin
        a_p = '0;
        b_p = '0;
        in_valid_v  = '0;
        en_v        = '0;
        out_ready_v = '1;
        held_v      = '0;
        for (int d = 0; d < NI; d++) begin
            acc_cnt[d] = 0;
            res_cnt[d] = 0;
        end

        // {a, b, en, {eq,lt,gt}, latency, hold out_ready low}
        vecs[0] = '{4'b1000, 4'b0111, 1'b1, 3'b001, 2, 1'b0};
        vecs[1] = '{4'b0101, 4'b0101, 1'b1, 3'b100, 5, 1'b0};
        vecs[2] = '{4'b0010, 4'b0011, 1'b1, 3'b010, 5, 1'b1};
        vecs[3] = '{4'b1111, 4'b0000, 1'b0, 3'b000, 1, 1'b0};
        vecs[4] = '{4'b0110, 4'b0100, 1'b1, 3'b001, 4, 1'b0};
        vecs[5] = '{4'b0000, 4'b0000, 1'b1, 3'b100, 5, 1'b0};
        vecs[6] = '{4'b0100, 4'b1100, 1'b1, 3'b010, 2, 1'b0};
        vecs[7] = '{4'b1001, 4'b1011, 1'b1, 3'b010, 4, 1'b0};
        vecs[8] = '{4'b1111, 4'b1111, 1'b0, 3'b000, 1, 1'b0};
        vecs[9] = '{4'b0111, 4'b0011, 1'b1, 3'b001, 3, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NI; d++) begin
            check($sformatf("reset_state_%0d", d),
                  {in_ready_v[d], out_valid_v[d], busy_v[d], eq_v[d], lt_v[d], gt_v[d]}, 6'b100000);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the second SHIFT cycle discards the transaction.
        a_p[0] = 7'b0000001;
        b_p[0] = 7'b0000000;
        en_v[0] = 1'b1;
        in_valid_v[0] = 1'b1;
        @(posedge clk); #1;
        in_valid_v[0] = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_busy", busy_v[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {in_ready_v[0], out_valid_v[0], busy_v[0], eq_v[0], lt_v[0], gt_v[0]}, 6'b100000);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(posedge clk); #1;
            check("rst_no_result", out_valid_v[0], 1'b0);
        end

        fork
            rand_run(0, 4, 256, 1'b1);
            rand_run(1, 7, 300, 1'b0);
        join

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NI; d++) begin
            check($sformatf("results_vs_accepts_%0d", d), res_cnt[d], acc_cnt[d]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
